// File: rtl/inert_pkg.sv
// inert_pkg: shared state encoding, default offsets/gains and the saturation helper
// for the inertial pitch complementary filter.
`default_nettype none

package inert_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [15:0] DEF_RT_OFF       = 16'h0050;
  localparam logic [15:0] DEF_AZ_OFF       = 16'h00A0;
  localparam int          DEF_ACC_GAIN     = 327;
  localparam int          DEF_ACC_SHIFT    = 13;
  localparam int          DEF_FUSE_SLOW    = 1024;
  localparam int          DEF_FUSE_FAST    = 8192;
  localparam int          DEF_SETTLE_SMPLS = 512;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/inert_acc_pitch.sv
// inert_acc_pitch: first pipeline stage -- offset removal on rate and AZ, AZ to pitch
// scaling with saturation, registered together with the stage valid.
`default_nettype none

module inert_acc_pitch
  import inert_pkg::*;
#(
  parameter int           W         = 16,
  parameter logic [W-1:0] RT_OFF    = DEF_RT_OFF,
  parameter logic [W-1:0] AZ_OFF    = DEF_AZ_OFF,
  parameter int           ACC_GAIN  = DEF_ACC_GAIN,
  parameter int           ACC_SHIFT = DEF_ACC_SHIFT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vld,
  input  logic                clr,
  input  logic [W-1:0]        ptch_rt,
  input  logic [W-1:0]        az,
  output logic [W-1:0]        rt_c,
  output logic signed [W-1:0] acc,
  output logic                s1_vld
);

  localparam logic signed [2*W-1:0] GAIN = (2*W)'(ACC_GAIN);

  logic [W-1:0]          rt_sub;
  logic [W-1:0]          az_sub;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] shifted;
  logic signed [63:0]    shifted_ext;
  logic signed [63:0]    acc_sat;
  logic                  unused_acc_hi;

  always_comb begin
    rt_sub      = ptch_rt - RT_OFF;
    az_sub      = az - AZ_OFF;
    prod        = $signed({{W{az_sub[W-1]}}, az_sub}) * GAIN;
    shifted     = prod >>> ACC_SHIFT;
    shifted_ext = {{(64-2*W){shifted[2*W-1]}}, shifted};
    acc_sat     = sat_signed(shifted_ext, W);
  end

  assign unused_acc_hi = ^acc_sat[63:W];

  // clr kills the sample entering this stage so nothing reaches the integrator next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_c   <= '0;
      acc    <= '0;
      s1_vld <= 1'b0;
    end else if (clr) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= vld;
      if (vld) begin
        rt_c <= rt_sub;
        acc  <= acc_sat[W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/inertial_integrator_gen.sv
// inertial_integrator_gen: two-stage pitch complementary filter with saturating integrator.
// INERT_FAST_SETTLE_EN enables the SETTLE phase with the fast fusion gain.
`default_nettype none

module inertial_integrator_gen
  import inert_pkg::*;
#(
  parameter int           W            = 16,
  parameter int           FRAC         = 11,
  parameter logic [W-1:0] RT_OFF       = DEF_RT_OFF,
  parameter logic [W-1:0] AZ_OFF       = DEF_AZ_OFF,
  parameter int           ACC_GAIN     = DEF_ACC_GAIN,
  parameter int           ACC_SHIFT    = DEF_ACC_SHIFT,
  parameter int           FUSE_SLOW    = DEF_FUSE_SLOW,
  parameter int           FUSE_FAST    = DEF_FUSE_FAST,
  parameter int           SETTLE_SMPLS = DEF_SETTLE_SMPLS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld,
  input  logic [W-1:0] ptch_rt,
  input  logic [W-1:0] AZ,
  input  logic         clr,
  output logic [W-1:0] ptch,
  output logic         ptch_vld,
  output logic         settled
);

  localparam int IW = W + FRAC;
  localparam int XW = IW + 2;

  logic [W-1:0]          rt_c;
  logic signed [W-1:0]   acc;
  logic                  s1_vld;
  logic signed [IW-1:0]  integ;
  logic signed [W-1:0]   ptch_s;
  logic signed [XW-1:0]  gain;
  logic signed [XW-1:0]  fuse;
  logic signed [XW-1:0]  integ_sum;
  logic signed [63:0]    integ_sat;
  logic                  unused_sat_hi;
  state_t                state;

  inert_acc_pitch #(
    .W         (W),
    .RT_OFF    (RT_OFF),
    .AZ_OFF    (AZ_OFF),
    .ACC_GAIN  (ACC_GAIN),
    .ACC_SHIFT (ACC_SHIFT)
  ) u_acc_pitch (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (vld),
    .clr     (clr),
    .ptch_rt (ptch_rt),
    .az      (AZ),
    .rt_c    (rt_c),
    .acc     (acc),
    .s1_vld  (s1_vld)
  );

  assign ptch_s = $signed(integ[IW-1:FRAC]);
  assign ptch   = ptch_s;

  // Two guard bits keep integ - rt_c + fuse exact before clamping.
  always_comb begin
    if (acc > ptch_s) begin
      fuse = gain;
    end else if (acc < ptch_s) begin
      fuse = -gain;
    end else begin
      fuse = '0;
    end
    integ_sum = {{2{integ[IW-1]}}, integ} - {{(XW-W){rt_c[W-1]}}, rt_c} + fuse;
    integ_sat = sat_signed({{(64-XW){integ_sum[XW-1]}}, integ_sum}, IW);
  end

  assign unused_sat_hi = ^integ_sat[63:IW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ    <= '0;
      ptch_vld <= 1'b0;
    end else if (clr) begin
      integ    <= '0;
      ptch_vld <= 1'b0;
    end else begin
      ptch_vld <= s1_vld;
      if (s1_vld) begin
        integ <= integ_sat[IW-1:0];
      end
    end
  end

`ifdef INERT_FAST_SETTLE_EN
  localparam int CW = (SETTLE_SMPLS > 1) ? $clog2(SETTLE_SMPLS) : 1;

  logic [CW-1:0] settle_cnt;

  assign gain = (state == RUN) ? XW'(FUSE_SLOW) : XW'(FUSE_FAST);

  // The sample that completes the count still uses the fast gain; settled lands with its ptch_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else if (s1_vld && (state != RUN)) begin
      if (settle_cnt == CW'(SETTLE_SMPLS - 1)) begin
        state   <= RUN;
        settled <= 1'b1;
      end else begin
        state      <= SETTLE;
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_settle_params = FUSE_FAST + SETTLE_SMPLS;

  assign gain = XW'(FUSE_SLOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      settled <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      settled <= 1'b0;
    end else if (s1_vld && (state == IDLE)) begin
      state   <= RUN;
      settled <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inertial_integrator_gen.sv
// Directed bench for inertial_integrator_gen; expectations follow whether
// INERT_FAST_SETTLE_EN is defined for the build.
`default_nettype none
`timescale 1ns/1ps

module tb_inertial_integrator_gen;

`ifdef INERT_FAST_SETTLE_EN
  localparam bit FAST     = 1'b1;
  localparam int SETTLE_N = 512;
`else
  localparam bit FAST     = 1'b0;
  localparam int SETTLE_N = 1;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        vld     = 1'b0;
  logic        clr     = 1'b0;
  logic [15:0] ptch_rt = 16'h0050;
  logic [15:0] az      = 16'h00A0;
  logic [15:0] ptch;
  logic        ptch_vld;
  logic        settled;

  int errors       = 0;
  int checks       = 0;
  int pulses       = 0;
  int first_settle = -1;
  int max_p        = 0;
  int min_p        = 0;

  always #5 clk = ~clk;

  inertial_integrator_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (vld),
    .ptch_rt  (ptch_rt),
    .AZ       (az),
    .clr      (clr),
    .ptch     (ptch),
    .ptch_vld (ptch_vld),
    .settled  (settled)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    int p;
    @(posedge clk);
    #1;
    p = $signed(ptch);
    if (ptch_vld === 1'b1) pulses++;
    if (settled === 1'b1 && first_settle < 0) first_settle = pulses;
    if (p > max_p) max_p = p;
    if (p < min_p) min_p = p;
  endtask

  // n back-to-back samples, then drain the pipeline.
  task automatic run_samples(input int n);
    vld = 1'b1;
    repeat (n) step();
    vld = 1'b0;
    step();
    step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic reset_extremes();
    max_p = -100000;
    min_p = 100000;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ptch", $signed(ptch), 0);
    chk("rst_ptch_vld", ptch_vld, 0);
    chk("rst_settled", settled, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Latency: single vld -> ptch_vld two edges later
    vld = 1'b1;
    step();
    vld = 1'b0;
    chk("lat_edge1", ptch_vld, 0);
    step();
    chk("lat_edge2", ptch_vld, 1);
    chk("lat_settled", settled, FAST ? 0 : 1);
    step();
    chk("lat_edge3", ptch_vld, 0);
    chk("lat_ptch", $signed(ptch), 0);

    // Plain clr
    do_clr();
    chk("clr_settled", settled, 0);
    chk("clr_ptch_vld", ptch_vld, 0);
    chk("clr_ptch", $signed(ptch), 0);

    // Stationary stream
    pulses = 0;
    first_settle = -1;
    vld = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step();
      chk("stat_ptch", $signed(ptch), 0);
      chk("stat_ptch_vld", ptch_vld, (i >= 1) ? 1 : 0);
    end
    vld = 1'b0;
    step();
    step();
    chk("stat_settle_pulse", first_settle, SETTLE_N);
    chk("stat_pulses", pulses, 600);

    // Tilt: acc = 163
    do_clr();
    az = 16'h10A0;
    reset_extremes();
    run_samples(20);
    chk("tilt_20", $signed(ptch), FAST ? 80 : 10);
    run_samples(492);
    chk("tilt_512", $signed(ptch), FAST ? 160 : 163);
    run_samples(88);
    chk("tilt_600", $signed(ptch), 163);
    chk("tilt_max", max_p, FAST ? 164 : 163);
    chk("tilt_min", min_p, 0);

    // Drift reject once settled
    do_clr();
    az = 16'h00A0;
    ptch_rt = 16'h0050;
    run_samples(SETTLE_N);
    chk("drift_settled", settled, 1);
    chk("drift_start", $signed(ptch), 0);
    ptch_rt = 16'h0450;
    run_samples(1);
    chk("drift_1", $signed(ptch), -1);
    reset_extremes();
    run_samples(50);
    chk("drift_51", $signed(ptch), -1);
    chk("drift_max", max_p, -1);
    chk("drift_min", min_p, -1);

    // Saturation: large positive rate held
    do_clr();
    ptch_rt = 16'h8000;
    reset_extremes();
    run_samples(3000);
    chk("sat_ptch", $signed(ptch), -32768);
    chk("sat_max", max_p, 0);
    run_samples(20);
    chk("sat_hold", $signed(ptch), -32768);
    chk("sat_min", min_p, -32768);

    // clr coincident with vld mid-stream
    do_clr();
    ptch_rt = 16'h0050;
    az = 16'h10A0;
    vld = 1'b1;
    repeat (5) step();
    chk("clrv_pre", $signed(ptch), FAST ? 16 : 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    vld = 1'b0;
    chk("clrv_vld_e0", ptch_vld, 0);
    chk("clrv_ptch", $signed(ptch), 0);
    chk("clrv_settled", settled, 0);
    step();
    chk("clrv_vld_e1", ptch_vld, 0);
    chk("clrv_ptch_e1", $signed(ptch), 0);
    step();
    chk("clrv_vld_e2", ptch_vld, 0);
    az = 16'h00A0;
    pulses = 0;
    first_settle = -1;
    run_samples(SETTLE_N);
    chk("clrv_resettle", first_settle, SETTLE_N);

    // Asynchronous reset mid-stream
    az = 16'h10A0;
    vld = 1'b1;
    repeat (6) step();
    chk("arst_pre", (ptch != 16'h0000) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ptch", $signed(ptch), 0);
    chk("arst_ptch_vld", ptch_vld, 0);
    chk("arst_settled", settled, 0);
    vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_vld_e1", ptch_vld, 0);
    step();
    chk("arst_vld_e2", ptch_vld, 0);
    chk("arst_ptch_e2", $signed(ptch), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inertial_integrator_gen.md
Name: inertial_integrator_gen

Overview:
Parametrised next-generation pitch complementary filter. It integrates the offset-compensated pitch rate and pulls the result toward an accelerometer-derived pitch through a signed fusion term. New relative to the fixed-width integrator:
- Registered two-stage pipeline with an output valid strobe.
- SETTLE/RUN state machine: large fusion gain while settling, small gain afterwards.
- Saturating integrator.
- Synchronous re-zero input.

It sits between the inertial interface (SPI readout of rate/AZ) and the balance controller.

Parameters:
W, 16, width of ptch_rt, AZ and ptch
FRAC, 11, integrator fractional bits (integrator width W+FRAC)
RT_OFF, 16'h0050, pitch-rate zero offset subtracted from ptch_rt
AZ_OFF, 16'h00A0, AZ zero offset subtracted from AZ
ACC_GAIN, 327, signed multiplier mapping AZ to pitch units
ACC_SHIFT, 13, arithmetic right shift applied to the AZ product
FUSE_SLOW, 1024, fusion magnitude in RUN
FUSE_FAST, 8192, fusion magnitude in SETTLE
SETTLE_SMPLS, 512, number of accepted samples spent in SETTLE

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
vld  in  1  new inertial sample present this cycle
ptch_rt  in  W  signed raw pitch rate
AZ  in  W  signed raw Z acceleration
clr  in  1  synchronous re-zero and restart settling
ptch  out  W  signed fused pitch = integ[W+FRAC-1:FRAC]
ptch_vld  out  1  one-cycle pulse: ptch updated this cycle
settled  out  1  high once SETTLE is complete

Behaviour:
- Reset (async, rst_n low): integ=0, all pipeline regs=0, ptch=0, ptch_vld=0, settled=0, state=IDLE, settle_cnt=0.
- Stage 1 (on vld):
  - rt_c = ptch_rt - RT_OFF, az_c = AZ - AZ_OFF, both W-bit wrapping subtract.
  - prod = az_c * ACC_GAIN at full 2W width.
  - acc = prod >>> ACC_SHIFT, saturated to the signed W range.
  - rt_c and acc are registered; s1_vld follows vld one cycle later.
- Stage 2 (on s1_vld):
  - fuse = +G if acc > ptch, -G if acc < ptch, 0 if equal. G = FUSE_FAST in SETTLE, FUSE_SLOW in RUN.
  - integ_next = integ - sext(rt_c) + fuse, computed at W+FRAC+2 bits, then saturated to [-2^(W+FRAC-1), 2^(W+FRAC-1)-1]. No wrap.
  - ptch_vld pulses the cycle integ updates.
- Latency: vld at cycle N gives a ptch update and ptch_vld at cycle N+2. Back-to-back vld is sustained at 1 sample/clk.
- FSM:
  - IDLE -> SETTLE on the first s1_vld. That sample already uses FUSE_FAST.
  - SETTLE: settle_cnt increments per s1_vld. When it reaches SETTLE_SMPLS-1, the next state is RUN. settled rises in the same cycle as that sample's ptch_vld.
  - RUN: holds until clr or reset. settle_cnt is frozen.
- clr (synchronous, priority over vld/s1_vld in the same cycle):
  - integ=0, s1_vld=0 (the in-flight sample is dropped), settle_cnt=0, settled=0, state=IDLE.
  - ptch_vld=0 in the following cycle.
- Reset mid-pipeline discards all in-flight samples.

Optional Feature:
INERT_FAST_SETTLE_EN:
- Defined: behaviour as above.
- Undefined: no SETTLE state or counter. IDLE -> RUN on the first s1_vld, G is always FUSE_SLOW, and settled rises with the first ptch_vld.

Decomposition:
- Package inert_pkg:
  - state enum typedef {IDLE, SETTLE, RUN}.
  - Default offset/gain localparams (RT_OFF, AZ_OFF, ACC_GAIN, ACC_SHIFT, FUSE_*).
  - Saturate function.
- Sub-module inert_acc_pitch: stage-1 offset subtract, multiply, shift and saturate, with its registers.

Test Plan:
- Stationary: ptch_rt=16'h0050, AZ=16'h00A0, 1000 vld -> ptch=0 throughout; ptch_vld 2 clk after each vld; settled rises at the 512th ptch_vld.
- Tilt: ptch_rt=16'h0050, AZ=16'h10A0 (acc=163) -> ptch climbs 4 per sample in SETTLE, then dithers within ±1 of 163 and never overshoots past 164.
- Drift reject (RUN, settled=1): ptch_rt=16'h0450 (rt_c=1024), AZ=16'h00A0 -> ptch moves negative by 1 LSB, then holds within ±1 of -1 (the fusion term cancels the rate).
- Saturation: ptch_rt=16'h8000 held -> integ clamps at -2^26, ptch=16'h8000 and stays there; no wrap to positive.
- clr asserted in the same cycle as vld mid-SETTLE -> no ptch_vld 2 clk later, ptch=0, settled=0, settle_cnt restarts; rst_n pulse mid-stream gives the same zero state asynchronously.
- Macro off: first sample -> settled=1 with its ptch_vld; the tilt test converges at 1024/2048 = 0.5 LSB per sample.
